// File: rtl/decode_imm_arith.sv
// decode_imm_arith: registered sub-decoder for RV32I OP-IMM instructions.
// Maps funct3/funct7 to an imm_arith_kind_t value for ALU operation select.
// Optional build macro DECODE_IMM_ARITH_RV64_SHAMT_EN: treat funct7[0] as
// shamt[5] for the shift encodings (RV64 form), otherwise match all 7 bits.

package instr_type;

  typedef enum logic [3:0] {
    iak_addi,
    iak_slti,
    iak_sltiu,
    iak_xori,
    iak_ori,
    iak_andi,
    iak_slli,
    iak_srli,
    iak_srai,
    iak_invalid
  } imm_arith_kind_t;

endpackage : instr_type

module decode_imm_arith
  import instr_type::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  output imm_arith_kind_t kind
);

`ifdef DECODE_IMM_ARITH_RV64_SHAMT_EN
  // funct7[0] carries shamt[5] in the RV64 form, so it takes no part in the match.
  localparam logic [6:0] shift_mask = 7'b111_1110;
`else
  localparam logic [6:0] shift_mask = 7'b111_1111;
`endif

  localparam logic [6:0] f7_logical    = 7'b000_0000;
  localparam logic [6:0] f7_arithmetic = 7'b010_0000;

  imm_arith_kind_t next_kind;
  logic [6:0]      f7_shift;

  assign f7_shift = funct7 & shift_mask;

  // Combinational next-kind decode; unknown funct3 falls to the default branch.
  always_comb begin
    // NOTE: default assignment first so every path drives next_kind and no latch is inferred.
    next_kind = iak_invalid;
    case (funct3)
      3'b000: next_kind = iak_addi;
      3'b010: next_kind = iak_slti;
      3'b011: next_kind = iak_sltiu;
      3'b100: next_kind = iak_xori;
      3'b110: next_kind = iak_ori;
      3'b111: next_kind = iak_andi;
      3'b001: begin
        if (f7_shift == f7_logical) next_kind = iak_slli;
        else                        next_kind = iak_invalid;
      end
      3'b101: begin
        if (f7_shift == f7_logical)         next_kind = iak_srli;
        else if (f7_shift == f7_arithmetic) next_kind = iak_srai;
        else                                next_kind = iak_invalid;
      end
      default: next_kind = iak_invalid;
    endcase
  end

  // Output register: synchronous reset to invalid, otherwise load next-kind every edge.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment so every register samples pre-edge values.
    if (rst) kind <= iak_invalid;
    else     kind <= next_kind;
  end

endmodule : decode_imm_arith

// File: tb/tb_decode_imm_arith.sv
// Self-checking bench for decode_imm_arith: directed test-plan cases followed
// by randomized decodes with occasional reset, checked against a table model.

module tb_decode_imm_arith;
  import instr_type::*;

`ifdef DECODE_IMM_ARITH_RV64_SHAMT_EN
  localparam bit rv64 = 1'b1;
`else
  localparam bit rv64 = 1'b0;
`endif

  logic            clk;
  logic            rst;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  imm_arith_kind_t kind;

  int checks = 0;
  int errors = 0;

  decode_imm_arith dut (
    .clk    (clk),
    .rst    (rst),
    .funct3 (funct3),
    .funct7 (funct7),
    .kind   (kind)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: opcode table by funct3 number, shift qualifier by value.
  function automatic imm_arith_kind_t model(input int f3, input int f7);
    imm_arith_kind_t table_k [8];
    int upper;
    table_k = '{iak_addi, iak_slli, iak_slti, iak_sltiu,
                iak_xori, iak_srli, iak_ori, iak_andi};
    upper = rv64 ? (f7 / 2) : f7;
    if (f3 == 1) return (upper == 0) ? iak_slli : iak_invalid;
    if (f3 == 5) begin
      if (upper == 0) return iak_srli;
      if (upper == (rv64 ? 16 : 32)) return iak_srai;
      return iak_invalid;
    end
    return table_k[f3];
  endfunction

  task automatic check(input string tag, input imm_arith_kind_t got,
                       input imm_arith_kind_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %s, expected %s", tag, got.name(), exp.name());
    end
  endtask

  // Drive inputs away from the edge, clock one edge, then sample just after it.
  task automatic step(input logic r, input logic [2:0] f3, input logic [6:0] f7,
                      input imm_arith_kind_t exp, input string tag);
    @(negedge clk);
    rst    = r;
    funct3 = f3;
    funct7 = f7;
    @(posedge clk);
    #1;
    check(tag, kind, exp);
  endtask

  initial begin
    int f3s [6];
    imm_arith_kind_t held;
    logic [2:0] r3;
    logic [6:0] r7;
    logic       rr;
    f3s = '{0, 2, 3, 4, 6, 7};

    rst    = 1'b1;
    funct3 = 3'b000;
    funct7 = 7'b000_0000;

    // Reset held for two edges, then first decode on release.
    step(1'b1, 3'b000, 7'h00, iak_invalid, "reset_edge1");
    step(1'b1, 3'b000, 7'h00, iak_invalid, "reset_edge2");
    step(1'b0, 3'b000, 7'h00, iak_addi,    "reset_release");

    // Non-shift sweep with funct7 all-zero and all-one.
    foreach (f3s[i]) begin
      step(1'b0, 3'(f3s[i]), 7'b000_0000, model(f3s[i], 0), $sformatf("nonshift_f3_%0d_f7_00", f3s[i]));
      step(1'b0, 3'(f3s[i]), 7'b111_1111, model(f3s[i], 127), $sformatf("nonshift_f3_%0d_f7_7f", f3s[i]));
    end

    // Shift encodings, valid and invalid.
    step(1'b0, 3'b001, 7'b000_0000, iak_slli,    "slli");
    step(1'b0, 3'b101, 7'b000_0000, iak_srli,    "srli");
    step(1'b0, 3'b101, 7'b010_0000, iak_srai,    "srai");
    step(1'b0, 3'b001, 7'b010_1010, iak_invalid, "slli_bad_f7");
    step(1'b0, 3'b101, 7'b010_1010, iak_invalid, "srx_bad_f7");
    step(1'b0, 3'b001, 7'b000_0001, rv64 ? iak_slli : iak_invalid, "slli_shamt5");
    step(1'b0, 3'b101, 7'b000_0001, rv64 ? iak_srli : iak_invalid, "srli_shamt5");
    step(1'b0, 3'b101, 7'b010_0001, rv64 ? iak_srai : iak_invalid, "srai_shamt5");
    step(1'b0, 3'b001, 7'b010_0000, iak_invalid, "slli_arith_f7");

    // Mid-cycle input change must not reach kind before the next edge.
    step(1'b0, 3'b111, 7'h00, iak_andi, "midcycle_before");
    held = kind;
    funct3 = 3'b100;
    #2;
    check("midcycle_hold", kind, iak_andi);
    @(posedge clk);
    #1;
    check("midcycle_after", kind, iak_xori);

    // Mid-stream reset during valid decodes.
    step(1'b0, 3'b010, 7'h00, iak_slti,    "stream_a");
    step(1'b1, 3'b011, 7'h00, iak_invalid, "stream_reset");
    step(1'b0, 3'b011, 7'h00, iak_sltiu,   "stream_resume");

    // Randomized back-to-back decodes with occasional reset.
    for (int n = 0; n < 300; n++) begin
      r3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       r7 = 7'b000_0000;
        1:       r7 = 7'b010_0000;
        2:       r7 = 7'($urandom_range(0, 1)) | (7'($urandom_range(0, 1)) << 5);
        default: r7 = 7'($urandom_range(0, 127));
      endcase
      rr = ($urandom_range(0, 15) == 0);
      step(rr, r3, r7, rr ? iak_invalid : model(int'(r3), int'(r7)),
           $sformatf("rand_%0d_r%0d_f3_%0d_f7_%02h", n, rr, r3, r7));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_decode_imm_arith

// File: doc/decode_imm_arith.md
# decode_imm_arith

Registered sub-decoder for RV32I OP-IMM (opcode 0010011) instructions. It maps `funct3` and `funct7` (instruction bits [14:12] and [31:25]) to one value of the `imm_arith_kind_t` enumeration from package `instr_type`. It sits inside the decode stage, after the opcode is classified as OP-IMM, and its `kind` output feeds ALU operation select.

## Interface
Parameters: none (the only option is the compile-time macro in Configuration).

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge
- `rst`  in  1  reset, synchronous, active-high
- `funct3`  in  3  instruction bits [14:12]
- `funct7`  in  7  instruction bits [31:25]; also the upper immediate bits for non-shift ops
- `kind`  out  `imm_arith_kind_t`  decoded operation
  - Members: `iak_addi`, `iak_slti`, `iak_sltiu`, `iak_xori`, `iak_ori`, `iak_andi`, `iak_slli`, `iak_srli`, `iak_srai`, `iak_invalid`.
  - Encoding is owned by `instr_type`. This block never assumes numeric values.

## Operation
Combinational next-kind, by `funct3`:
- 000 -> `iak_addi`; `funct7` ignored
- 010 -> `iak_slti`; `funct7` ignored
- 011 -> `iak_sltiu`; `funct7` ignored
- 100 -> `iak_xori`; `funct7` ignored
- 110 -> `iak_ori`; `funct7` ignored
- 111 -> `iak_andi`; `funct7` ignored
- 001:
  - `funct7` == 0000000 -> `iak_slli`
  - else -> `iak_invalid`
- 101:
  - `funct7` == 0000000 -> `iak_srli`
  - `funct7` == 0100000 -> `iak_srai`
  - else -> `iak_invalid`

Other rules:
- Any input containing X/Z decodes to `iak_invalid` (default branch). Simulation must not propagate X on `kind`.
- No opcode input. The caller qualifies `kind` with its own OP-IMM detect.
- Decode is a full case on `funct3` with an explicit default to `iak_invalid`. No latches.

## Timing
- `kind` is a register loaded with next-kind on every rising edge of `clk`.
- Latency is one cycle: inputs stable before edge N give `kind` valid after edge N and held until edge N+1.
- Reset: `rst` high at a rising edge forces `kind` to `iak_invalid`, overriding the inputs.
  - Applies from power-up and mid-stream alike.
  - The first decode after reset is the edge at which `rst` is sampled low.
- Input changes between edges have no effect until the next edge. There is no handshake or stall input.
- Back-to-back decodes every cycle are supported.

## Configuration
- `DECODE_IMM_ARITH_RV64_SHAMT_EN`, defined: 6-bit shift amount (RV64 form).
  - `funct7[0]` is treated as shamt[5] and ignored for `funct3` 001 and 101.
  - 001 accepts `funct7` 000000x as SLLI.
  - 101 accepts 000000x as SRLI and 010000x as SRAI.
- Undefined (default): strict RV32 match on all 7 bits. For example, `funct7` 0000001 with `funct3` 001 gives `iak_invalid`.
- No other behaviour differs between the two builds.

## Test plan
- Reset: hold `rst`=1 for 2 edges with `funct3`=000 -> `kind`==`iak_invalid`. Release -> after the next edge `kind`==`iak_addi`.
- Non-shift sweep, `funct7`=0000000:
  - `funct3` 000/010/011/100/110/111 -> `iak_addi`/`iak_slti`/`iak_sltiu`/`iak_xori`/`iak_ori`/`iak_andi`, each one cycle after apply.
  - Repeat with `funct7`=1111111 -> same results.
- Shifts:
  - (001, 0000000) -> `iak_slli`
  - (101, 0000000) -> `iak_srli`
  - (101, 0100000) -> `iak_srai`
- Invalid shifts:
  - (001, 0101010) -> `iak_invalid`; (101, 0101010) -> `iak_invalid`.
  - (001, 0000001) -> `iak_invalid` when the macro is undefined, `iak_slli` when defined.
- Latency and mid-stream reset:
  - Change inputs mid-cycle -> `kind` unchanged until the next rising edge.
  - Assert `rst` during a stream of valid decodes -> `iak_invalid` on the following edge.
